// File: rtl/punc_mem_arbiter_if.sv
// Bus bundle between the PUnC requesters (CPU, DBG), the memory arbiter and the memory macro.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface punc_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant_dbg;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    output mem_addr, mem_wdata, mem_we,
    output busy, grant_dbg
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  busy, grant_dbg
  );
endinterface

// File: rtl/punc_mem_arbiter.sv
// Round-robin CPU/DBG arbiter for the single-port PUnC memory, hiding the fixed read latency.
// Optional macro PUNC_ARB_DBG_LOCK_EN adds dbg_lock, letting DBG hold the memory for bulk loads.
module punc_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input logic clk,
  input logic rst,
`ifdef PUNC_ARB_DBG_LOCK_EN
  input logic dbg_lock,
`endif
  punc_mem_arbiter_if.slave bus
);

  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic              last_dbg;
  logic              we_q;
  logic              grant_dbg_q;
  logic              grant, pick_dbg, capture, lock_dbg;
  logic              pick_we;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              cpu_ack_q, dbg_ack_q;

`ifdef PUNC_ARB_DBG_LOCK_EN
  // Lock only sticks once DBG already owns the memory; CPU wins the tie after release.
  assign lock_dbg = dbg_lock && last_dbg;
`else
  assign lock_dbg = 1'b0;
`endif

  assign pick_we = pick_dbg ? bus.dbg_we : bus.cpu_we;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant    = 1'b0;
    pick_dbg = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (lock_dbg) begin
          pick_dbg = 1'b1;
          grant    = bus.dbg_req;
        end else if (bus.cpu_req && bus.dbg_req) begin
          pick_dbg = !last_dbg;
          grant    = 1'b1;
        end else if (bus.dbg_req) begin
          pick_dbg = 1'b1;
          grant    = 1'b1;
        end else if (bus.cpu_req) begin
          grant    = 1'b1;
        end
        if (grant) state_nx = ISSUE;
      end
      ISSUE: begin
        cnt_nx   = LAT_M1;
        state_nx = we_q ? ACK : WAIT;
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          capture  = 1'b1;
          state_nx = ACK;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      last_dbg    <= 1'b1;
      grant_dbg_q <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      // Request fields are latched only at grant; later changes are ignored.
      if (grant) begin
        mem_addr_q  <= pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
        mem_wdata_q <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        we_q        <= pick_we;
        last_dbg    <= pick_dbg;
        grant_dbg_q <= pick_dbg;
      end
      // Grant is the only way into ISSUE, so the strobe spans exactly that cycle.
      mem_we_q <= grant && pick_we;
      if (capture && grant_dbg_q)  dbg_rdata_q <= bus.mem_rdata;
      if (capture && !grant_dbg_q) cpu_rdata_q <= bus.mem_rdata;
      cpu_ack_q <= (state_nx == ACK) && !grant_dbg_q;
      dbg_ack_q <= (state_nx == ACK) && grant_dbg_q;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.busy      = (state != IDLE);
  assign bus.grant_dbg = grant_dbg_q;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Directed bench for punc_mem_arbiter: one instance with READ_LAT=1 (b1), one with READ_LAT=3 (b3).
// Each instance drives a behavioural memory that returns 16'hDEAD outside the read-valid cycle.
module tb_punc_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  punc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
  punc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b3 ();

`ifdef PUNC_ARB_DBG_LOCK_EN
  logic dbg_lock = 1'b0;
  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .dbg_lock(dbg_lock), .bus(b1));
  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .dbg_lock(1'b0), .bus(b3));
`else
  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1));
  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3));
`endif

  // Memory models: the read is launched in the first busy cycle (ISSUE) of a read.
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic        busy1_d, busy3_d;
  logic        v1;
  logic [15:0] d1;
  logic [2:0]  v3;
  logic [15:0] d3 [3];

  always @(posedge clk) begin
    busy1_d <= b1.busy;
    if (b1.mem_we) mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
    v1 <= b1.busy && !busy1_d && !b1.mem_we;
    d1 <= mem1[b1.mem_addr[7:0]];
    busy3_d <= b3.busy;
    if (b3.mem_we) mem3[b3.mem_addr[7:0]] <= b3.mem_wdata;
    v3 <= {v3[1:0], b3.busy && !busy3_d && !b3.mem_we};
    d3[0] <= mem3[b3.mem_addr[7:0]];
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end

  assign b1.mem_rdata = v1    ? d1    : 16'hDEAD;
  assign b3.mem_rdata = v3[2] ? d3[2] : 16'hDEAD;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dbg_req = 0; b1.dbg_we = 0; b1.dbg_addr = '0; b1.dbg_wdata = '0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.dbg_req = 0; b3.dbg_we = 0; b3.dbg_addr = '0; b3.dbg_wdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    n_tests++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %h want 0", b1.busy); end
    n_tests++; if (b1.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %h want 0", b1.mem_we); end
    n_tests++; if ({b1.cpu_ack, b1.dbg_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_acks got %b want 00", {b1.cpu_ack, b1.dbg_ack}); end
    n_tests++; if (b1.mem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h want 0000", b1.mem_addr); end
    n_tests++; if (b1.mem_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_mem_wdata got %h want 0000", b1.mem_wdata); end
    n_tests++; if ({b1.cpu_rdata, b1.dbg_rdata} !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", {b1.cpu_rdata, b1.dbg_rdata}); end
    n_tests++; if (b1.grant_dbg !== 1'b0) begin n_fail++; $display("FAIL rst_grant_dbg got %h want 0", b1.grant_dbg); end
    tick();
    rst = 1'b0;
    tick();
    n_tests++; if (b3.busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got %h want 0", b3.busy); end
  endtask

  task automatic test_write;
    // cycle 0
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 16'h3000; b1.cpu_wdata = 16'h1234;
    n_tests++; if (b1.mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_c0_we got %h want 0", b1.mem_we); end
    tick(); // cycle 1
    b1.cpu_wdata = 16'hFFFF;
    n_tests++; if (b1.mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_c1_we got %h want 1", b1.mem_we); end
    n_tests++; if (b1.mem_addr !== 16'h3000) begin n_fail++; $display("FAIL wr_c1_addr got %h want 3000", b1.mem_addr); end
    n_tests++; if (b1.mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL wr_c1_wdata got %h want 1234", b1.mem_wdata); end
    n_tests++; if (b1.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_c1_ack got %h want 0", b1.cpu_ack); end
    tick(); // cycle 2
    n_tests++; if (b1.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_c2_ack got %h want 1", b1.cpu_ack); end
    n_tests++; if (b1.dbg_ack !== 1'b0) begin n_fail++; $display("FAIL wr_c2_dbg_ack got %h want 0", b1.dbg_ack); end
    n_tests++; if (b1.mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_c2_we got %h want 0", b1.mem_we); end
    b1.cpu_req = 0;
    tick(); // cycle 3
    n_tests++; if ({b1.cpu_ack, b1.dbg_ack, b1.busy} !== 3'b000) begin n_fail++; $display("FAIL wr_c3_idle got %b want 000", {b1.cpu_ack, b1.dbg_ack, b1.busy}); end
    n_tests++; if (b1.mem_addr !== 16'h3000) begin n_fail++; $display("FAIL wr_addr_hold got %h want 3000", b1.mem_addr); end
    n_tests++; if (mem1[8'h00] !== 16'h1234) begin n_fail++; $display("FAIL wr_mem got %h want 1234", mem1[8'h00]); end
  endtask

  task automatic test_read_lat1;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h0005;
    tick(); // cycle 1
    n_tests++; if (b1.mem_we !== 1'b0) begin n_fail++; $display("FAIL rd1_c1_we got %h want 0", b1.mem_we); end
    tick(); // cycle 2
    n_tests++; if (b1.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rd1_c2_ack got %h want 0", b1.cpu_ack); end
    tick(); // cycle 3
    n_tests++; if (b1.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rd1_c3_ack got %h want 1", b1.cpu_ack); end
    n_tests++; if (b1.cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd1_rdata got %h want beef", b1.cpu_rdata); end
    b1.cpu_req = 0;
    tick();
    // A DBG write follows; cpu_rdata must hold.
    b1.dbg_req = 1; b1.dbg_we = 1; b1.dbg_addr = 16'h0077; b1.dbg_wdata = 16'h9999;
    tick();
    tick();
    n_tests++; if (b1.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL dbg_wr_ack got %h want 1", b1.dbg_ack); end
    n_tests++; if (b1.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL dbg_wr_cpu_ack got %h want 0", b1.cpu_ack); end
    n_tests++; if (b1.grant_dbg !== 1'b1) begin n_fail++; $display("FAIL dbg_wr_grant got %h want 1", b1.grant_dbg); end
    b1.dbg_req = 0;
    tick();
    n_tests++; if (b1.cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd1_hold got %h want beef", b1.cpu_rdata); end
    n_tests++; if (mem1[8'h77] !== 16'h9999) begin n_fail++; $display("FAIL dbg_wr_mem got %h want 9999", mem1[8'h77]); end
  endtask

  task automatic test_round_robin;
    int k;
    logic want_dbg;
    do_reset();
    k = 0;
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 16'h0010; b1.cpu_wdata = 16'h1111;
    b1.dbg_req = 1; b1.dbg_we = 1; b1.dbg_addr = 16'h0011; b1.dbg_wdata = 16'h2222;
    for (int c = 0; c < 40 && k < 4; c++) begin
      if (b1.cpu_ack || b1.dbg_ack) begin
        want_dbg = k[0];
        n_tests++; if ({b1.cpu_ack, b1.dbg_ack} !== {!want_dbg, want_dbg}) begin n_fail++; $display("FAIL rr_ack%0d got %b want %b", k, {b1.cpu_ack, b1.dbg_ack}, {!want_dbg, want_dbg}); end
        n_tests++; if (b1.grant_dbg !== want_dbg) begin n_fail++; $display("FAIL rr_grant%0d got %h want %h", k, b1.grant_dbg, want_dbg); end
        n_tests++; if (c !== 2 + 3 * k) begin n_fail++; $display("FAIL rr_cycle%0d got %0d want %0d", k, c, 2 + 3 * k); end
        k++;
        if (k == 4) begin b1.cpu_req = 0; b1.dbg_req = 0; end
      end
      tick();
    end
    n_tests++; if (k !== 4) begin n_fail++; $display("FAIL rr_count got %0d want 4", k); end
    b1.cpu_req = 0; b1.dbg_req = 0;
    tick();
    n_tests++; if (mem1[8'h10] !== 16'h1111 || mem1[8'h11] !== 16'h2222) begin n_fail++; $display("FAIL rr_mem got %h/%h want 1111/2222", mem1[8'h10], mem1[8'h11]); end
  endtask

  task automatic test_read_lat3;
    b3.dbg_req = 1; b3.dbg_we = 0; b3.dbg_addr = 16'h0022;
    for (int c = 0; c < 9; c++) begin
      n_tests++; if (b3.dbg_ack !== (c == 5)) begin n_fail++; $display("FAIL rd3_ack c%0d got %h want %h", c, b3.dbg_ack, (c == 5)); end
      n_tests++; if (b3.busy !== (c >= 1 && c <= 5)) begin n_fail++; $display("FAIL rd3_busy c%0d got %h want %h", c, b3.busy, (c >= 1 && c <= 5)); end
      if (c == 1) begin
        n_tests++; if (b3.mem_addr !== 16'h0022) begin n_fail++; $display("FAIL rd3_addr got %h want 0022", b3.mem_addr); end
      end
      if (c == 5) begin
        n_tests++; if (b3.dbg_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL rd3_rdata got %h want a5a5", b3.dbg_rdata); end
        b3.dbg_req = 0;
      end
      n_tests++; if (b3.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rd3_cpu_ack c%0d got %h want 0", c, b3.cpu_ack); end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait;
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 16'h0022;
    tick(); // ISSUE
    tick(); // WAIT
    tick(); // WAIT
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if ({b3.busy, b3.cpu_ack, b3.dbg_ack, b3.mem_we, b3.grant_dbg} !== 5'b0) begin n_fail++; $display("FAIL mid_rst_ctl got %b want 00000", {b3.busy, b3.cpu_ack, b3.dbg_ack, b3.mem_we, b3.grant_dbg}); end
    n_tests++; if (b3.mem_addr !== 16'h0) begin n_fail++; $display("FAIL mid_rst_addr got %h want 0000", b3.mem_addr); end
    n_tests++; if ({b3.cpu_rdata, b3.dbg_rdata} !== 32'h0) begin n_fail++; $display("FAIL mid_rst_rdata got %h want 0", {b3.cpu_rdata, b3.dbg_rdata}); end
    b3.cpu_req = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_tests++; if (b3.cpu_ack !== 1'b0 || b3.cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL mid_rst_no_ack c%0d got %h/%h want 0/0000", c, b3.cpu_ack, b3.cpu_rdata); end
      tick();
    end
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 16'h0030;
    for (int c = 0; c < 8; c++) begin
      n_tests++; if (b3.cpu_ack !== (c == 5)) begin n_fail++; $display("FAIL post_rst_ack c%0d got %h want %h", c, b3.cpu_ack, (c == 5)); end
      if (c == 5) begin
        n_tests++; if (b3.cpu_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL post_rst_rdata got %h want 5a5a", b3.cpu_rdata); end
        b3.cpu_req = 0;
      end
      tick();
    end
  endtask

`ifdef PUNC_ARB_DBG_LOCK_EN
  task automatic test_dbg_lock;
    int k;
    do_reset();
    k = 0;
    dbg_lock = 1'b1;
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 16'h0040; b1.cpu_wdata = 16'h4040;
    b1.dbg_req = 1; b1.dbg_we = 1; b1.dbg_addr = 16'h0041; b1.dbg_wdata = 16'h4141;
    for (int c = 0; c < 60 && k < 6; c++) begin
      if (b1.cpu_ack || b1.dbg_ack) begin
        n_tests++; if ({b1.cpu_ack, b1.dbg_ack} !== ((k < 5) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL lock_ack%0d got %b want %b", k, {b1.cpu_ack, b1.dbg_ack}, (k < 5) ? 2'b01 : 2'b10); end
        k++;
        if (k == 5) dbg_lock = 1'b0;
        if (k == 6) begin b1.cpu_req = 0; b1.dbg_req = 0; end
      end
      tick();
    end
    n_tests++; if (k !== 6) begin n_fail++; $display("FAIL lock_count got %0d want 6", k); end
    b1.cpu_req = 0; b1.dbg_req = 0;
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'h0;
      mem3[i] = 16'h0;
    end
    mem1[8'h05] = 16'hBEEF;
    mem3[8'h22] = 16'hA5A5;
    mem3[8'h30] = 16'h5A5A;
    v1 = 1'b0; v3 = 3'b0; busy1_d = 1'b0; busy3_d = 1'b0;
    test_reset();
    test_write();
    test_read_lat1();
    test_round_robin();
    test_read_lat3();
    test_reset_mid_wait();
`ifdef PUNC_ARB_DBG_LOCK_EN
    test_dbg_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
